// File: rtl/btc_nonce_fifo.sv
// btc_nonce_fifo: first-word fall-through FIFO that buffers nonces reported by
// a mining core, with sticky overflow / done flags and a level interrupt.
// A push and a pop in the same cycle are both accepted, even when the FIFO is full.
// The interrupt output is built only when BTC_NONCE_FIFO_IRQ_EN is defined.
// Without that macro, irq is tied low and the design has no irq flop.
module btc_nonce_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [31:0]      found_nonce,
    input  logic             found_valid,
    input  logic             core_done,
    input  logic             clear,
    input  logic             pop,
    output logic [31:0]      head_nonce,
    output logic             head_valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             done_seen,
    output logic             irq
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             pop_ok;
    logic             push_ok;
    logic             core_done_q;

    assign head_valid = (count != '0);
    assign full       = (count == CNT_W'(DEPTH));
    // A pop on an empty FIFO is ignored.
    assign pop_ok     = pop && head_valid;
    // When full, a concurrent pop frees the slot that the push then reuses.
    assign push_ok    = found_valid && (!full || pop_ok);
    // The head is read straight from storage, so a new entry is visible right after its push edge.
    assign head_nonce = head_valid ? mem[rd_ptr] : 32'h0;

    // Storage write at the tail; a clear in the same cycle suppresses the write.
    // NOTE: the data array has no reset; count and head_valid qualify every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= found_nonce;
        end
    end

    // Pointer and occupancy bookkeeping; clear overrides push and pop.
    // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Sticky overflow / done flags, plus the core_done history used for the rising-edge detect.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            overflow    <= 1'b0;
            done_seen   <= 1'b0;
            core_done_q <= 1'b0;
        end else begin
            core_done_q <= core_done;
            if (clear) begin
                overflow  <= 1'b0;
                done_seen <= 1'b0;
            end else begin
                if (found_valid && full && !pop) overflow  <= 1'b1;
                if (core_done && !core_done_q)   done_seen <= 1'b1;
            end
        end
    end

`ifdef BTC_NONCE_FIFO_IRQ_EN
    // Registered interrupt: follows the pending-work / flag state one cycle later.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= head_valid | overflow | done_seen;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_btc_nonce_fifo.sv
// tb_btc_nonce_fifo: scoreboard bench for btc_nonce_fifo.
// The driver issues one cycle of stimulus at a time and keeps an abstract model:
// an occupancy number, flag values, and a data queue holding the expected FIFO contents.
// A separate monitor compares the presented head against the front of that queue on
// every falling edge. It retires an entry whenever a pop is accepted.
// Reads the BTC_NONCE_FIFO_IRQ_EN macro to decide whether irq should behave as an interrupt or stay low.
module tb_btc_nonce_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             arst_n;
    logic [31:0]      found_nonce;
    logic             found_valid;
    logic             core_done;
    logic             clear;
    logic             pop;
    logic [31:0]      head_nonce;
    logic             head_valid;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             done_seen;
    logic             irq;

    btc_nonce_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .found_nonce(found_nonce),
        .found_valid(found_valid),
        .core_done  (core_done),
        .clear      (clear),
        .pop        (pop),
        .head_nonce (head_nonce),
        .head_valid (head_valid),
        .count      (count),
        .overflow   (overflow),
        .done_seen  (done_seen),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Scoreboard: the expected FIFO contents, oldest first.
    logic [31:0] sb_q[$];

    // Abstract model state, valid after each clock edge.
    int   mdl_cnt;
    logic mdl_ovf;
    logic mdl_done;
    logic mdl_irq;
    logic prev_cd;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: checks the presented head, then applies the pop or clear that the next edge will perform.
    initial begin
        forever begin
            @(negedge clk);
            if (arst_n) begin
                check("head_valid", {31'd0, head_valid}, {31'd0, sb_q.size() != 0});
                if (sb_q.size() != 0) begin
                    check("head_nonce", head_nonce, sb_q[0]);
                end else begin
                    check("head_nonce_empty", head_nonce, 32'h0);
                end
                if (clear) begin
                    sb_q.delete();
                end else if (pop && sb_q.size() != 0) begin
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus, followed by the model update and the state checks after the edge.
    task automatic cyc(input logic fv, input logic [31:0] n, input logic p,
                       input logic c, input logic cd);
        logic pre_hv;
        logic pre_ovf;
        logic pre_done;
        logic pop_eff;
        logic push_eff;
        found_valid = fv;
        found_nonce = n;
        pop         = p;
        clear       = c;
        core_done   = cd;
        @(posedge clk);
        #1;
        pre_hv   = (mdl_cnt != 0);
        pre_ovf  = mdl_ovf;
        pre_done = mdl_done;
        pop_eff  = p && pre_hv;
        if (c) begin
            mdl_cnt  = 0;
            mdl_ovf  = 1'b0;
            mdl_done = 1'b0;
        end else begin
            push_eff = fv && (mdl_cnt < DEPTH || pop_eff);
            if (push_eff) sb_q.push_back(n);
            if (fv && mdl_cnt == DEPTH && !p) mdl_ovf = 1'b1;
            mdl_cnt = mdl_cnt + (push_eff ? 1 : 0) - (pop_eff ? 1 : 0);
            if (cd && !prev_cd) mdl_done = 1'b1;
        end
        prev_cd = cd;
`ifdef BTC_NONCE_FIFO_IRQ_EN
        mdl_irq = pre_hv | pre_ovf | pre_done;
`else
        mdl_irq = 1'b0;
`endif
        check("count",     {{(32 - CNT_W){1'b0}}, count}, 32'(mdl_cnt));
        check("overflow",  {31'd0, overflow},  {31'd0, mdl_ovf});
        check("done_seen", {31'd0, done_seen}, {31'd0, mdl_done});
        check("irq",       {31'd0, irq},       {31'd0, mdl_irq});
    endtask

    task automatic model_reset();
        sb_q.delete();
        mdl_cnt  = 0;
        mdl_ovf  = 1'b0;
        mdl_done = 1'b0;
        mdl_irq  = 1'b0;
        prev_cd  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"},      {{(32 - CNT_W){1'b0}}, count}, 32'h0);
        check({tag, "_head_valid"}, {31'd0, head_valid}, 32'h0);
        check({tag, "_head_nonce"}, head_nonce, 32'h0);
        check({tag, "_overflow"},   {31'd0, overflow},  32'h0);
        check({tag, "_done_seen"},  {31'd0, done_seen}, 32'h0);
        check({tag, "_irq"},        {31'd0, irq},       32'h0);
    endtask

    initial begin
        arst_n      = 1'b0;
        found_nonce = '0;
        found_valid = 1'b0;
        core_done   = 1'b0;
        clear       = 1'b0;
        pop         = 1'b0;
        model_reset();
        #2;
        check_all_zero("reset");
        #10;
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single push, then a pop.
        cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        check("single_head", head_nonce, 32'hDEADBEEF);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("single_empty", {31'd0, head_valid}, 32'h0);

        // A pop on an empty FIFO is ignored.
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Fill past capacity, then drain in order.
        for (int i = 1; i <= 9; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        check("fill_overflow", {31'd0, overflow}, 32'h1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Push and pop together while full.
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
        check("full_pp_overflow", {31'd0, overflow}, 32'h0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("full_pp_last", head_nonce, 32'hA5A5A5A5);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Wrap-around with interleaved push/pop pairs.
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        end

        // A clear takes priority over a push in the same cycle.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hFFFF0000, 1'b0, 1'b1, 1'b0);
        check("clear_head_valid", {31'd0, head_valid}, 32'h0);

        // The rising edge of done sets done_seen, which then raises irq when interrupts are enabled.
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("done_set", {31'd0, done_seen}, 32'h1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'h3000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h3001, 1'b0, 1'b0, 1'b0);

        // Assert reset during a push/pop, then check that the next push goes into an empty FIFO.
        found_valid = 1'b1;
        found_nonce = 32'h4444;
        pop         = 1'b1;
        arst_n      = 1'b0;
        #2;
        check_all_zero("midreset");
        found_valid = 1'b0;
        pop         = 1'b0;
        model_reset();
        arst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h5555AAAA, 1'b0, 1'b0, 1'b0);
        check("post_reset_head", head_nonce, 32'h5555AAAA);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic cd_r;
            cd_r = ($urandom_range(0, 3) == 0) ? ~core_done : core_done;
            cyc(1'($urandom_range(0, 1)), $urandom(), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 39) == 0), cd_r);
        end

        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/btc_nonce_fifo.md
BTC_NONCE_FIFO -- requirements
Module: btc_nonce_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of result entries; power of two, 2..16.
REQ-002 SHALL have parameter CNT_W, default 4, equal to clog2(DEPTH)+1, width of the occupancy count.
REQ-003 SHALL have port clk, input, 1, mining core clock; single clock domain.
REQ-004 SHALL have port arst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port found_nonce, input, 32, nonce reported by the mining core.
REQ-006 SHALL have port found_valid, input, 1, single-cycle strobe qualifying found_nonce.
REQ-007 SHALL have port core_done, input, 1, level done flag from the mining core.
REQ-008 SHALL have port clear, input, 1, synchronous flush of FIFO and sticky flags.
REQ-009 SHALL have port pop, input, 1, consumer removes the head entry.
REQ-010 SHALL have port head_nonce, output, 32, oldest stored nonce (first-word fall-through).
REQ-011 SHALL have port head_valid, output, 1, FIFO not empty.
REQ-012 SHALL have port count, output, CNT_W, number of stored entries.
REQ-013 SHALL have port overflow, output, 1, sticky flag: a nonce was dropped.
REQ-014 SHALL have port done_seen, output, 1, sticky flag: rising edge of core_done seen.
REQ-015 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-016 SHALL write found_nonce into the tail on a clk edge with found_valid=1 when not full or when pop=1 in the same cycle.
REQ-017 SHALL present a pushed entry on head_nonce/head_valid one cycle after the push edge when the FIFO was empty.
REQ-018 SHALL advance the head on a clk edge with pop=1 and head_valid=1; pop with head_valid=0 SHALL be ignored, and count SHALL stay 0.
REQ-019 SHALL, on simultaneous push and pop, keep count unchanged, including when full, without setting overflow.
REQ-020 SHALL drop the nonce and set overflow on found_valid=1 when count==DEPTH and pop=0.
REQ-021 SHALL wrap read and write pointers modulo DEPTH; count SHALL never exceed DEPTH.
REQ-022 SHALL hold head_nonce stable while head_valid=1 and pop=0; head_nonce SHALL be 0 when empty.
REQ-023 SHALL set done_seen one cycle after a 0->1 transition of core_done; a registered copy of core_done SHALL supply the edge detect.
REQ-024 SHALL, on clear=1, empty the FIFO and clear overflow and done_seen next edge; clear SHALL take priority over push, pop and edge-detect in the same cycle.

Reset
REQ-025 SHALL, on arst_n=0, asynchronously force pointers, count, head_valid, head_nonce, overflow, done_seen, irq and the core_done history register to 0.
REQ-026 SHALL discard any in-flight push or pop when reset asserts mid-operation; after release, the first found_valid SHALL be treated as a push into an empty FIFO.

Configuration
REQ-027 SHALL, with BTC_NONCE_FIFO_IRQ_EN defined, drive irq registered as head_valid OR overflow OR done_seen, asserting one cycle after the triggering state.
REQ-028 SHALL, without BTC_NONCE_FIFO_IRQ_EN, tie irq to constant 0 and include no irq flop.

Verification
REQ-029 SHALL cover single push: found_nonce=0xDEADBEEF strobe -> next cycle head_valid=1, head_nonce=0xDEADBEEF, count=1; pop -> head_valid=0, count=0.
REQ-030 SHALL cover fill and overflow: 9 pushes of 0x1..0x9, DEPTH=8 -> count=8, overflow=1; popping 8 times returns 0x1..0x8 in order.
REQ-031 SHALL cover push+pop while full: count=8, found_valid and pop together with 0xA5A5A5A5 -> count stays 8, overflow stays 0, 0xA5A5A5A5 is read last.
REQ-032 SHALL cover wrap-around: 20 interleaved push/pop pairs with incrementing nonces -> data order preserved, count never exceeds 1.
REQ-033 SHALL cover clear vs. push in the same cycle: count=3, clear=1 and found_valid=1 -> count=0, head_valid=0, overflow=0, done_seen=0.
REQ-034 SHALL cover done and irq: core_done 0->1 -> done_seen=1 next cycle; irq=1 one cycle later with the macro defined, irq=0 without it; arst_n pulse -> all outputs 0.
